// File: rtl/io_input_conditioner.sv
// io_input_conditioner: 2-flop sync + per-bit debounce with rise/fall strobes; db_o lags io_in by DEBOUNCE_CYCLES+2 edges.
// No backpressure (free-running every cycle). Define IO_EDGE_LATCH_EN to enable sticky edge flags on sticky_o.
module io_input_conditioner #(
  parameter int WIDTH           = 38,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic [WIDTH-1:0] io_in,
  input  logic [WIDTH-1:0] en_mask_i,
  input  logic [WIDTH-1:0] edge_clr_i,
  output logic [WIDTH-1:0] db_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] sticky_o
);

  localparam int               CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [0:0]       ST_STABLE  = 1'b0;
  localparam logic [0:0]       ST_PENDING = 1'b1;

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] db_q, db_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] state_w;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Per-bit state is implicit: a bit is PENDING whenever its synchronized level disagrees with db.
  assign state_w = s2_q ^ db_q;

  always_comb begin
    db_d   = db_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (en_mask_i[i] && (state_w[i] == ST_PENDING)) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i]   = s2_q[i];
          rise_d[i] = s2_q[i];
          fall_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end else if (state_w[i] == ST_STABLE) begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      s1_q   <= '0;
      s2_q   <= '0;
      db_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q   <= io_in;
      s2_q   <= s1_q;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign db_o   = db_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

`ifdef IO_EDGE_LATCH_EN
  logic [WIDTH-1:0] sticky_q, sticky_d;

  // Set term comes from the registered strobes, so a clear sampled during the pulse cycle loses.
  assign sticky_d = (sticky_q & ~edge_clr_i) | rise_q | fall_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) sticky_q <= '0;
    else            sticky_q <= sticky_d;
  end

  assign sticky_o = sticky_q;
`else
  logic unused_edge_clr;
  assign unused_edge_clr = ^edge_clr_i;
  assign sticky_o        = '0;
`endif

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner (WIDTH=8, DEBOUNCE_CYCLES=4): vector table, corner sequences, random vs window model.
module tb_io_input_conditioner;
  localparam int W  = 8;
  localparam int DC = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] io_in, en_mask, edge_clr;
  logic [W-1:0] db, rise, fall, sticky;

  io_input_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .io_in     (io_in),
    .en_mask_i (en_mask),
    .edge_clr_i(edge_clr),
    .db_o      (db),
    .rise_o    (rise),
    .fall_o    (fall),
    .sticky_o  (sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a bit commits once the last DC synchronized samples all
  // disagree with the held level and all DC of those edges were enabled.
  logic [W-1:0]  m_p1, m_p2, m_db, m_rise, m_fall, m_sticky;
  logic [DC-1:0] m_hs [W];
  logic [DC-1:0] m_he [W];

  task automatic model_reset();
    m_p1 = '0; m_p2 = '0; m_db = '0; m_rise = '0; m_fall = '0; m_sticky = '0;
    for (int i = 0; i < W; i++) begin
      m_hs[i] = '0;
      m_he[i] = '0;
    end
  endtask

  task automatic model_edge(input logic [W-1:0] io, input logic [W-1:0] en, input logic [W-1:0] clr);
`ifdef IO_EDGE_LATCH_EN
    m_sticky = (m_sticky & ~clr) | m_rise | m_fall;
`else
    m_sticky = '0;
    if (clr == 8'hA5) m_sticky = '0;
`endif
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < W; i++) begin
      m_hs[i] = {m_hs[i][DC-2:0], m_p2[i]};
      m_he[i] = {m_he[i][DC-2:0], en[i]};
      if ((&m_he[i]) && (m_hs[i] == {DC{~m_db[i]}})) begin
        m_db[i] = ~m_db[i];
        if (m_db[i]) m_rise[i] = 1'b1;
        else         m_fall[i] = 1'b1;
      end
    end
    m_p2 = m_p1;
    m_p1 = io;
  endtask

  task automatic step(input logic [W-1:0] io, input logic [W-1:0] en, input logic [W-1:0] clr);
    io_in    = io;
    en_mask  = en;
    edge_clr = clr;
    @(posedge clk);
    model_edge(io, en, clr);
    #1;
  endtask

  typedef struct {
    logic [W-1:0] io;
    logic [W-1:0] db;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } vec_t;
  vec_t tbl [8];

  logic [W-1:0] cur_io;
  logic         sticky_on;
  int           rise_at, nr, nf, bad;
  bit           seen;

  initial begin
`ifdef IO_EDGE_LATCH_EN
    sticky_on = 1'b1;
`else
    sticky_on = 1'b0;
`endif
    // bit0 held high from row 0; bit1 high for only 3 rows (glitch rejected)
    for (int k = 0; k < 8; k++) begin
      tbl[k].io   = (k < 3) ? 8'h03 : 8'h01;
      tbl[k].db   = (k < 5) ? 8'h00 : 8'h01;
      tbl[k].rise = (k == 5) ? 8'h01 : 8'h00;
      tbl[k].fall = 8'h00;
    end

    rst_n = 1'b0; io_in = '0; en_mask = '1; edge_clr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_db", db, 0);
    chk("reset_rise", rise, 0);
    chk("reset_fall", fall, 0);
    chk("reset_sticky", sticky, 0);
    rst_n = 1'b1;
    repeat (3) step(8'h00, 8'hFF, 8'h00);

    for (int k = 0; k < 8; k++) begin
      step(tbl[k].io, 8'hFF, 8'h00);
      chk($sformatf("tbl%0d_db", k), db, tbl[k].db);
      chk($sformatf("tbl%0d_rise", k), rise, tbl[k].rise);
      chk($sformatf("tbl%0d_fall", k), fall, tbl[k].fall);
    end

    cur_io = 8'h01;
    for (int k = 0; k < 10; k++) begin
      cur_io[2] = (k % 2 == 0);
      step(cur_io, 8'hFF, 8'h00);
      chk($sformatf("toggle%0d_db2", k), db[2], 0);
    end
    cur_io[2] = 1'b1;
    rise_at = -1; nr = 0; nf = 0;
    for (int j = 0; j < 8; j++) begin
      step(cur_io, 8'hFF, 8'h00);
      if (rise[2]) begin nr++; rise_at = j; end
      if (fall[2]) nf++;
    end
    chk("toggle_rise_count", nr, 1);
    chk("toggle_fall_count", nf, 0);
    chk("toggle_rise_edge", rise_at, 5);

    cur_io[3] = 1'b1;
    bad = 0;
    for (int j = 0; j < 20; j++) begin
      step(cur_io, 8'hF7, 8'h00);
      if (db[3] | rise[3] | fall[3]) bad++;
    end
    chk("masked_bit3_quiet", bad, 0);
    rise_at = -1; nr = 0;
    for (int j = 0; j < 6; j++) begin
      step(cur_io, 8'hFF, 8'h00);
      if (rise[3]) begin nr++; rise_at = j; end
    end
    chk("reenable_rise_count", nr, 1);
    chk("reenable_rise_edge", rise_at, 3);
    chk("reenable_db", db, 8'h0D);

    cur_io[4] = 1'b1;
    repeat (4) step(cur_io, 8'hFF, 8'h00);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_db", db, 0);
    chk("midrst_rise", rise, 0);
    chk("midrst_fall", fall, 0);
    chk("midrst_sticky", sticky, 0);
    @(posedge clk);
    #1;
    chk("rst_held_db", db, 0);
    #1 rst_n = 1'b1;
    nr = 0;
    for (int j = 0; j < 8; j++) begin
      step(cur_io, 8'hFF, 8'h00);
      nr += $countones(rise) + $countones(fall);
      if (j == 4) chk("postrst_db_e5", db, 0);
      if (j == 5) begin
        chk("postrst_db_e6", db, cur_io);
        chk("postrst_rise_e6", rise, cur_io);
      end
    end
    chk("postrst_pulse_count", nr, 4);

    cur_io[5] = 1'b1;
    seen = 0;
    for (int j = 0; j < 10 && !seen; j++) begin
      step(cur_io, 8'hFF, 8'h00);
      if (rise[5]) seen = 1;
    end
    chk("sticky_rise_seen", seen, 1);
    step(cur_io, 8'hFF, 8'h00);
    chk("sticky_set", sticky[5], sticky_on);
    repeat (2) step(cur_io, 8'hFF, 8'h00);
    chk("sticky_hold", sticky[5], sticky_on);
    cur_io[5] = 1'b0;
    seen = 0;
    for (int j = 0; j < 10 && !seen; j++) begin
      step(cur_io, 8'hFF, 8'h00);
      if (fall[5]) seen = 1;
    end
    chk("sticky_fall_seen", seen, 1);
    step(cur_io, 8'hFF, 8'h20);
    chk("sticky_set_wins", sticky[5], sticky_on);
    step(cur_io, 8'hFF, 8'h00);
    chk("sticky_still_set", sticky[5], sticky_on);
    step(cur_io, 8'hFF, 8'h20);
    chk("sticky_cleared", sticky[5], 0);

    for (int n = 0; n < 400; n++) begin
      logic [W-1:0] flip, en, clr;
      for (int i = 0; i < W; i++) begin
        flip[i] = (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
        en[i]   = ($urandom_range(0, 9) != 0);
        clr[i]  = ($urandom_range(0, 3) == 0);
      end
      cur_io = cur_io ^ flip;
      step(cur_io, en, clr);
      chk($sformatf("rnd%0d_db", n), db, m_db);
      chk($sformatf("rnd%0d_rise", n), rise, m_rise);
      chk($sformatf("rnd%0d_fall", n), fall, m_fall);
      chk($sformatf("rnd%0d_sticky", n), sticky, m_sticky);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
